reg_writeback_ctrl: RTL and testbench

Write-side controller for the pipeline register file. That register file performs either one write or one read pair per clock, never both. This block accepts MEM/WB writebacks and buffers them in a small FIFO. It drains the FIFO into the register file on cycles when decode is not reading, and forwards still-pending values to decode so reads are never stale.

---
 rtl/reg_writeback_ctrl_pkg.sv | 18 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/reg_writeback_ctrl.sv | 136 +++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types for the register-file writeback controller.
// Widths, the buffered writeback entry and controller states.
package reg_writeback_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending writebacks.
// Entries are exposed oldest-first so the forwarding search can prefer the youngest.
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]         valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset; validity comes from count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
      valid[i]   = CW'(i) < count;
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Buffers MEM/WB writebacks and drains them into a single-port register file.
// Pending values are forwarded to decode; a starved full buffer forces a write.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wb_valid,
  input  logic                   wb_mem_to_reg,
  input  logic [DATA_W-1:0]      wb_alu_result,
  input  logic [DATA_W-1:0]      wb_mem_data,
  input  logic [REG_ADDR_W-1:0]  wb_dest,
  output logic                   wb_ready,
  input  logic                   read_req,
  input  logic [REG_ADDR_W-1:0]  read_addr_a,
  input  logic [REG_ADDR_W-1:0]  read_addr_b,
  output logic                   read_grant,
  output logic                   fwd_a_valid,
  output logic [DATA_W-1:0]      fwd_a_data,
  output logic                   fwd_b_valid,
  output logic [DATA_W-1:0]      fwd_b_data,
  output logic [REG_ADDR_W-1:0]  rf_write_address,
  output logic [DATA_W-1:0]      rf_write_data,
  output logic                   rf_reg_write,
  output logic [$clog2(DEPTH):0] pending_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  wb_state_e             state_q;
  wb_state_e             state_d;
  logic [SW-1:0]         starve_q;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  starve_cond;
  logic                  starve_hit;

  assign full          = count == CW'(DEPTH);
  assign empty         = count == '0;
  assign wb_ready      = !full;
  assign pending_count = count;

  // $zero writes complete the handshake but are dropped here.
  assign push = wb_valid && wb_ready && (wb_dest != '0);

  assign push_entry.dest = wb_dest;
  assign push_entry.data = wb_mem_to_reg ? wb_mem_data
                                         : wb_alu_result;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (rf_reg_write),
    .head       (head),
    .count      (count),
    .entries    (entries),
    .valid      (valid)
  );

  assign starve_cond = read_req && full;
  assign starve_hit  = starve_cond &&
                       (starve_q == SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (!starve_cond || starve_hit) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_NORMAL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NORMAL: if (starve_hit) state_d = ST_FORCE;
      ST_FORCE:  state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    read_grant   = read_req;
    rf_reg_write = !empty && !read_req;
    unique case (state_q)
      ST_NORMAL: ;
      ST_FORCE: begin
        read_grant   = 1'b0;
        rf_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_write_address = rf_reg_write ? head.dest : '0;
  assign rf_write_data    = rf_reg_write ? head.data : '0;

  // Entries are oldest-first, so the last match is the youngest.
  always_comb begin
    fwd_a_valid = 1'b0;
    fwd_a_data  = '0;
    fwd_b_valid = 1'b0;
    fwd_b_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && read_addr_a != '0 &&
          entries[i].dest == read_addr_a) begin
        fwd_a_valid = 1'b1;
        fwd_a_data  = entries[i].data;
      end
      if (valid[i] && read_addr_b != '0 &&
          entries[i].dest == read_addr_b) begin
        fwd_b_valid = 1'b1;
        fwd_b_data  = entries[i].data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: queue-based model of
// pending writes, starvation rule and forwarding, plus write-order checker.
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_valid, wb_mem_to_reg;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [4:0]  wb_dest;
  logic        wb_ready;
  logic        read_req;
  logic [4:0]  read_addr_a, read_addr_b;
  logic        read_grant;
  logic        fwd_a_valid, fwd_b_valid;
  logic [31:0] fwd_a_data, fwd_b_data;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic [2:0]  pending_count;

  int vectors = 0;
  int miscompares = 0;

  wb_entry_t pend[$];
  wb_entry_t exp_q[$];
  int        streak = 0;
  bit        force_m = 1'b0;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .wb_valid         (wb_valid),
    .wb_mem_to_reg    (wb_mem_to_reg),
    .wb_alu_result    (wb_alu_result),
    .wb_mem_data      (wb_mem_data),
    .wb_dest          (wb_dest),
    .wb_ready         (wb_ready),
    .read_req         (read_req),
    .read_addr_a      (read_addr_a),
    .read_addr_b      (read_addr_b),
    .read_grant       (read_grant),
    .fwd_a_valid      (fwd_a_valid),
    .fwd_a_data       (fwd_a_data),
    .fwd_b_valid      (fwd_b_valid),
    .fwd_b_data       (fwd_b_data),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_reg_write     (rf_reg_write),
    .pending_count    (pending_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic lookup(input logic [4:0] a,
                        output logic v,
                        output logic [31:0] d);
    v = 1'b0;
    d = '0;
    if (a != 0) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].dest == a) begin
          v = 1'b1;
          d = pend[i].data;
          break;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic m2r,
                      input logic [31:0] alu,
                      input logic [31:0] mem,
                      input logic [4:0] dest,
                      input logic rr,
                      input logic [4:0] ra,
                      input logic [4:0] rb);
    int          n;
    logic        we, fv, cond, nforce;
    logic [31:0] fd;
    wb_entry_t   e;
    @(negedge clock);
    wb_valid      = v;
    wb_mem_to_reg = m2r;
    wb_alu_result = alu;
    wb_mem_data   = mem;
    wb_dest       = dest;
    read_req      = rr;
    read_addr_a   = ra;
    read_addr_b   = rb;
    #1;
    n  = pend.size();
    we = force_m || (!rr && n != 0);
    chk("wb_ready", 32'(wb_ready), 32'(n != DEPTH));
    chk("read_grant", 32'(read_grant), 32'(rr && !force_m));
    chk("rf_reg_write", 32'(rf_reg_write), 32'(we));
    chk("wr_addr_gate", 32'(rf_write_address),
        we ? 32'(pend[0].dest) : 32'd0);
    chk("wr_data_gate", rf_write_data,
        we ? pend[0].data : 32'd0);
    chk("pending_count", 32'(pending_count), 32'(n));
    lookup(ra, fv, fd);
    chk("fwd_a_valid", 32'(fwd_a_valid), 32'(fv));
    chk("fwd_a_data", fwd_a_data, fd);
    lookup(rb, fv, fd);
    chk("fwd_b_valid", 32'(fwd_b_valid), 32'(fv));
    chk("fwd_b_data", fwd_b_data, fd);
    cond   = rr && n == DEPTH;
    nforce = !force_m && cond && streak == LIMIT - 1;
    if (!cond || nforce) streak = 0;
    else                 streak++;
    if (we) void'(pend.pop_front());
    if (v && n != DEPTH && dest != 0) begin
      e.dest = dest;
      e.data = m2r ? mem : alu;
      pend.push_back(e);
      exp_q.push_back(e);
    end
    force_m = nforce;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, rr, 5'd0, 5'd0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) idle(1'b0);
  endtask

  // Write-order scoreboard: every RF write must match the oldest accept.
  always @(negedge clock) begin
    wb_entry_t e;
    #2;
    if (reset_n && rf_reg_write) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %h data %h, want none",
                 rf_write_address, rf_write_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(rf_write_address), 32'(e.dest));
        chk("sb_data", rf_write_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int prob[3];
    int nf;
    prob = '{30, 85, 97};
    reset_n = 1'b0;
    wb_valid = 0; wb_mem_to_reg = 0; wb_dest = 0;
    wb_alu_result = 0; wb_mem_data = 0;
    read_req = 1'b1; read_addr_a = 5'd3; read_addr_b = 5'd4;
    #3;
    chk("rst_count", 32'(pending_count), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_we", 32'(rf_reg_write), 32'd0);
    chk("rst_addr", 32'(rf_write_address), 32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_fwd", 32'({fwd_a_valid, fwd_b_valid}), 32'd0);
    chk("rst_fwd_data", fwd_a_data | fwd_b_data, 32'd0);
    chk("rst_grant", 32'(read_grant), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // single write, written the cycle after accept
    step(1, 0, 32'h1234, 32'h0, 5'd5, 0, 5'd5, 5'd0);
    step(0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd5, 5'd0);
    idle(1'b0);

    // same dest twice while reading: youngest forwarded
    step(1, 0, 32'hAAAA, 0, 5'd7, 1, 5'd7, 5'd7);
    step(1, 0, 32'hBBBB, 0, 5'd7, 1, 5'd7, 5'd7);
    step(0, 0, 0, 0, 5'd0, 1, 5'd7, 5'd0);
    chk("fwd_youngest", fwd_a_data, 32'hBBBB);
    drain();

    // $zero destination
    step(1, 0, 32'hFFFF, 32'hFFFF, 5'd0, 0, 5'd0, 5'd0);
    idle(1'b0);
    chk("zero_count", 32'(pending_count), 32'd0);

    // fill and starve: exactly one forced write
    for (int i = 1; i <= DEPTH; i++)
      step(1, 0, 32'h100 + i, 0, 5'(i), 1, 5'd1, 5'd2);
    nf = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 32'h200 + i, 0, 5'd9, 1, 5'd9, 5'd1);
      if (!read_grant) nf++;
    end
    chk("force_cycles", 32'(nf), 32'd1);
    drain();

    // mem select with concurrent push/pop
    step(1, 0, 32'h11, 0, 5'd2, 1, 5'd0, 5'd0);
    step(1, 0, 32'h22, 0, 5'd3, 1, 5'd0, 5'd0);
    step(1, 1, 32'h33, 32'hDEAD, 5'd4, 0, 5'd4, 5'd0);
    idle(1'b0);
    chk("concurrent_count", 32'(pending_count), 32'd2);
    drain();

    // reset mid-drain
    for (int i = 1; i <= 3; i++)
      step(1, 0, 32'h300 + i, 0, 5'(i + 10), 1, 5'd0, 5'd0);
    idle(1'b0);
    @(negedge clock);
    wb_valid = 0; read_req = 0;
    read_addr_a = 0; read_addr_b = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_count", 32'(pending_count), 32'd0);
    chk("async_we", 32'(rf_reg_write), 32'd0);
    chk("async_ready", 32'(wb_ready), 32'd1);
    pend.delete();
    exp_q.delete();
    streak = 0;
    force_m = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    drain();

    // randomized phases with rising read pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 300; k++) begin
        step(1'($urandom_range(99) < 60),
             1'($urandom_range(1)),
             $urandom, $urandom,
             5'($urandom_range(7)),
             1'($urandom_range(99) < prob[ph]),
             5'($urandom_range(7)),
             5'($urandom_range(7)));
      end
      drain();
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
